onchip_ram_arbiter: RTL

//  Shares the single-port 2560x32 on-chip RAM between two Avalon-MM masters (m0, m1).

---
 rtl/onchip_ram_arbiter_if.sv | 26 ++
 rtl/onchip_ram_arbiter.sv | 83 ++++++++
 2 files changed

// File: rtl/onchip_ram_arbiter_if.sv
// Avalon-MM master-side bundle for one master of the on-chip RAM arbiter.
// The master modport is the interconnect side; the slave modport is the arbiter side.
interface onchip_ram_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_ram_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two Avalon-MM masters,
// with 1-cycle read-return tracking, out-of-range blocking and sticky error flags.
module onchip_ram_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int RAM_DEPTH = 2560
) (
  input  logic               clk,
  input  logic               reset_n,
  onchip_ram_arbiter_if.slave m0,
  onchip_ram_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]  ram_address,
  output logic [BE_W-1:0]    ram_byteenable,
  output logic               ram_chipselect,
  output logic               ram_write,
  output logic [DATA_W-1:0]  ram_writedata,
  output logic               ram_clken,
  input  logic [DATA_W-1:0]  ram_readdata,
  output logic               oor_err,
  output logic               proto_err
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(RAM_DEPTH);

  logic active;      // high from the first clock after reset release
  logic last_grant;  // 0 = m0, 1 = m1
  logic rv_pend, rv_owner, rv_oor;

  logic req0, req1, grant0, grant1, sel, acc;
  logic acc_wr, acc_rd, acc_oor;

  always_comb begin
    req0    = m0.read | m0.write;
    req1    = m1.read | m1.write;
    grant0  = active & req0 & (~req1 | last_grant);
    grant1  = active & req1 & (~req0 | ~last_grant);
    sel     = grant1;
    acc     = grant0 | grant1;
    // read+write together is a write; the read half is dropped
    acc_wr  = sel ? m1.write : m0.write;
    acc_rd  = (sel ? m1.read : m0.read) & ~acc_wr;
    ram_address    = sel ? m1.address    : m0.address;
    ram_byteenable = sel ? m1.byteenable : m0.byteenable;
    ram_writedata  = sel ? m1.writedata  : m0.writedata;
    acc_oor        = {1'b0, ram_address} >= DEPTH;
    ram_chipselect = acc & ~acc_oor;
    ram_write      = ram_chipselect & acc_wr;
  end

  assign ram_clken = active;

  assign m0.waitrequest   = ~active | (req0 & ~grant0);
  assign m1.waitrequest   = ~active | (req1 & ~grant1);
  assign m0.readdatavalid = rv_pend & ~rv_owner;
  assign m1.readdatavalid = rv_pend &  rv_owner;
  assign m0.readdata      = (rv_pend & ~rv_owner & ~rv_oor) ? ram_readdata : '0;
  assign m1.readdata      = (rv_pend &  rv_owner & ~rv_oor) ? ram_readdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active     <= 1'b0;
      last_grant <= 1'b1;
      rv_pend    <= 1'b0;
      rv_owner   <= 1'b0;
      rv_oor     <= 1'b0;
      oor_err    <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      active   <= 1'b1;
      rv_pend  <= acc & acc_rd;
      rv_owner <= sel;
      rv_oor   <= acc_oor;
      if (acc)
        last_grant <= sel;
      if (acc & acc_oor)
        oor_err <= 1'b1;
      if (active & ((m0.read & m0.write) | (m1.read & m1.write)))
        proto_err <= 1'b1;
    end
  end

endmodule
